// File: rtl/reflet_float_to_int_seq_if.sv
// Handshake and data bundle between a requester and the sequential
// float-to-integer converter.
interface reflet_float_to_int_seq_if #(
   parameter int float_size = 32,
   parameter int int_size   = 32
);
   logic                  start;
   logic [float_size-1:0] float_in;
   logic                  busy;
   logic                  done;
   logic [int_size-1:0]   int_out;
   logic [1:0]            flag_out;

   modport master (
      output start,
      output float_in,
      input  busy,
      input  done,
      input  int_out,
      input  flag_out
   );

   modport slave (
      input  start,
      input  float_in,
      output busy,
      output done,
      output int_out,
      output flag_out
   );
endinterface

// File: rtl/reflet_float_to_int_seq.sv
// Multi-cycle float-to-integer converter. The significand is moved one bit
// per clock (left or right) until it lines up with the integer LSB, then the
// result is negated if needed. Rounding is toward zero; out-of-range values
// saturate and set flag_out[0], NaN returns 0 with flag_out[1].
module reflet_float_to_int_seq #(
   parameter int float_size = 32,
   parameter int int_size   = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   reflet_float_to_int_seq_if.slave bus
);
   localparam int E    = (float_size == 16) ? 5 : ((float_size == 64) ? 11 : 8);
   localparam int M    = float_size - 1 - E;
   localparam int BIAS = (1 << (E - 1)) - 1;
   localparam int W    = (int_size > M + 1) ? int_size : M + 1;
   // Signed exponent arithmetic width: wide enough for e - M and int_size-1.
   localparam int EW   = E + 3;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_FINISH = 2'd2
   } state_t;

   // Result class decided when the operand is accepted.
   typedef enum logic [2:0] {
      K_NORM = 3'd0,
      K_ZERO = 3'd1,
      K_SAT  = 3'd2,
      K_NAN  = 3'd3,
      K_MIN  = 3'd4
   } kind_t;

   localparam logic [int_size-1:0] MAX_POS = {1'b0, {(int_size-1){1'b1}}};
   localparam logic [int_size-1:0] MIN_NEG = {1'b1, {(int_size-1){1'b0}}};

   state_t                state_q, state_d;
   kind_t                 kind_q, kind_d;
   logic                  sign_q, sign_d;
   logic                  left_q, left_d;
   logic [EW-1:0]         count_q, count_d;
   logic [W-1:0]          shreg_q, shreg_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic [int_size-1:0]   int_q, int_d;
   logic [1:0]            flag_q, flag_d;

   logic                  in_sign_s;
   logic [E-1:0]          in_exp_s;
   logic [M-1:0]          in_mant_s;
   logic signed [EW-1:0]  e_s;
   logic signed [EW-1:0]  s_s;
   logic [EW-1:0]         abs_s;
   kind_t                 in_kind_s;
   logic [int_size-1:0]   mag_s;

   // Operand decode and classification of the value on float_in.
   always_comb begin
      in_sign_s = bus.float_in[float_size-1];
      in_exp_s  = bus.float_in[float_size-2 -: E];
      in_mant_s = bus.float_in[M-1:0];
      e_s       = $signed({3'b000, in_exp_s}) - $signed(EW'(BIAS));
      s_s       = e_s - $signed(EW'(M));
      if (s_s < $signed(EW'(0))) begin
         abs_s = EW'(-s_s);
      end else begin
         abs_s = EW'(s_s);
      end
      if (in_exp_s == {E{1'b1}}) begin
         if (in_mant_s != {M{1'b0}}) begin
            in_kind_s = K_NAN;
         end else begin
            in_kind_s = K_SAT;
         end
      end else if (e_s < $signed(EW'(0))) begin
         in_kind_s = K_ZERO;
      end else if (e_s >= $signed(EW'(int_size - 1))) begin
         if ((e_s == $signed(EW'(int_size - 1))) && in_sign_s && (in_mant_s == {M{1'b0}})) begin
            in_kind_s = K_MIN;
         end else begin
            in_kind_s = K_SAT;
         end
      end else begin
         in_kind_s = K_NORM;
      end
   end

   // Next-state and next-output computation for the IDLE/SHIFT/FINISH sequence.
   always_comb begin
      state_d = state_q;
      kind_d  = kind_q;
      sign_d  = sign_q;
      left_d  = left_q;
      count_d = count_q;
      shreg_d = shreg_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      int_d   = int_q;
      flag_d  = flag_q;
      mag_s   = shreg_q[int_size-1:0];
      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               state_d = ST_SHIFT;
               kind_d  = in_kind_s;
               sign_d  = in_sign_s;
               left_d  = (s_s > $signed(EW'(0)));
               shreg_d = W'({1'b1, in_mant_s});
               busy_d  = 1'b1;
               if (in_kind_s == K_NORM) begin
                  count_d = abs_s;
               end else begin
                  count_d = {EW{1'b0}};
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            if (count_q != {EW{1'b0}}) begin
               count_d = count_q - EW'(1);
               if (left_q) begin
                  shreg_d = {shreg_q[W-2:0], 1'b0};
               end else begin
                  shreg_d = {1'b0, shreg_q[W-1:1]};
               end
            end else begin
               state_d = ST_FINISH;
               done_d  = 1'b1;
               case (kind_q)
                  K_NORM: begin
                     int_d  = sign_q ? (~mag_s + int_size'(1)) : mag_s;
                     flag_d = 2'b00;
                  end
                  K_ZERO: begin
                     int_d  = {int_size{1'b0}};
                     flag_d = 2'b00;
                  end
                  K_SAT: begin
                     int_d  = sign_q ? MIN_NEG : MAX_POS;
                     flag_d = 2'b01;
                  end
                  K_NAN: begin
                     int_d  = {int_size{1'b0}};
                     flag_d = 2'b10;
                  end
                  K_MIN: begin
                     int_d  = MIN_NEG;
                     flag_d = 2'b00;
                  end
                  default: begin
                     int_d  = {int_size{1'b0}};
                     flag_d = 2'b00;
                  end
               endcase
            end
         end
         ST_FINISH: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and datapath registers; reset aborts any conversion in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         kind_q  <= K_NORM;
         sign_q  <= 1'b0;
         left_q  <= 1'b0;
         count_q <= {EW{1'b0}};
         shreg_q <= {W{1'b0}};
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         int_q   <= {int_size{1'b0}};
         flag_q  <= 2'b00;
      end else begin
         state_q <= state_d;
         kind_q  <= kind_d;
         sign_q  <= sign_d;
         left_q  <= left_d;
         count_q <= count_d;
         shreg_q <= shreg_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         int_q   <= int_d;
         flag_q  <= flag_d;
      end
   end

   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.int_out  = int_q;
   assign bus.flag_out = flag_q;
endmodule

// File: tb/tb_reflet_float_to_int_seq.sv
// Directed bench for reflet_float_to_int_seq (float_size=32, int_size=32).
module tb_reflet_float_to_int_seq;
   logic clk;
   logic rst_n;
   int   pass_cnt;
   int   total_cnt;

   reflet_float_to_int_seq_if #(.float_size(32), .int_size(32)) bus ();

   reflet_float_to_int_seq #(.float_size(32), .int_size(32)) dut (
      .clk   (clk),
      .reset (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Runs one conversion; edges = rising edges from acceptance to done (-1 on timeout).
   task automatic convert(input logic [31:0] f, output logic [31:0] r, output logic [1:0] fl,
                          output int edges, output int busy_cyc, output logic idle_ok);
      @(negedge clk);
      bus.float_in = f;
      bus.start    = 1'b1;
      @(posedge clk);
      #1;
      bus.start    = 1'b0;
      bus.float_in = 32'hDEADBEEF;
      busy_cyc     = bus.busy ? 1 : 0;
      edges        = -1;
      for (int i = 1; i <= 200; i++) begin
         @(posedge clk);
         #1;
         if (bus.busy) busy_cyc++;
         if (bus.done) begin
            edges = i;
            break;
         end
      end
      r  = bus.int_out;
      fl = bus.flag_out;
      @(posedge clk);
      #1;
      idle_ok = !bus.busy && !bus.done && (bus.int_out === r) && (bus.flag_out === fl);
   endtask

   task automatic test_reset();
      rst_n        = 1'b0;
      bus.start    = 1'b0;
      bus.float_in = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      total_cnt++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else pass_cnt++;
      total_cnt++; if (bus.done !== 1'b0) $display("FAIL reset_done got %b want 0", bus.done); else pass_cnt++;
      total_cnt++; if (bus.int_out !== 32'h0) $display("FAIL reset_int got %h want 0", bus.int_out); else pass_cnt++;
      total_cnt++; if (bus.flag_out !== 2'b00) $display("FAIL reset_flag got %b want 00", bus.flag_out); else pass_cnt++;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_right_shift();
      logic [31:0] r; logic [1:0] fl; int ed, bc; logic ok;
      convert(32'h42600000, r, fl, ed, bc, ok);
      total_cnt++; if (ed !== 19) $display("FAIL r56_latency got %0d want 19", ed); else pass_cnt++;
      total_cnt++; if (bc !== 20) $display("FAIL r56_busy got %0d want 20", bc); else pass_cnt++;
      total_cnt++; if (r !== 32'h00000038) $display("FAIL r56_int got %h want 00000038", r); else pass_cnt++;
      total_cnt++; if (fl !== 2'b00) $display("FAIL r56_flag got %b want 00", fl); else pass_cnt++;
      total_cnt++; if (ok !== 1'b1) $display("FAIL r56_idle got %b want 1", ok); else pass_cnt++;
      convert(32'hC4094000, r, fl, ed, bc, ok);
      total_cnt++; if (ed !== 15) $display("FAIL m549_latency got %0d want 15", ed); else pass_cnt++;
      total_cnt++; if (r !== 32'hFFFFFDDB) $display("FAIL m549_int got %h want FFFFFDDB", r); else pass_cnt++;
      total_cnt++; if (fl !== 2'b00) $display("FAIL m549_flag got %b want 00", fl); else pass_cnt++;
      convert(32'h3F400000, r, fl, ed, bc, ok);
      total_cnt++; if (ed !== 1) $display("FAIL f075_latency got %0d want 1", ed); else pass_cnt++;
      total_cnt++; if (r !== 32'h0) $display("FAIL f075_int got %h want 0", r); else pass_cnt++;
      total_cnt++; if (fl !== 2'b00) $display("FAIL f075_flag got %b want 00", fl); else pass_cnt++;
   endtask

   task automatic test_left_shift();
      logic [31:0] r; logic [1:0] fl; int ed, bc; logic ok;
      convert(32'h4E800000, r, fl, ed, bc, ok);
      total_cnt++; if (ed !== 8) $display("FAIL p2e30_latency got %0d want 8", ed); else pass_cnt++;
      total_cnt++; if (r !== 32'h40000000) $display("FAIL p2e30_int got %h want 40000000", r); else pass_cnt++;
      total_cnt++; if (fl !== 2'b00) $display("FAIL p2e30_flag got %b want 00", fl); else pass_cnt++;
      convert(32'hCE800000, r, fl, ed, bc, ok);
      total_cnt++; if (r !== 32'hC0000000) $display("FAIL m2e30_int got %h want C0000000", r); else pass_cnt++;
      total_cnt++; if (fl !== 2'b00) $display("FAIL m2e30_flag got %b want 00", fl); else pass_cnt++;
   endtask

   task automatic test_saturation();
      logic [31:0] r; logic [1:0] fl; int ed, bc; logic ok;
      convert(32'h4F32D05E, r, fl, ed, bc, ok);
      total_cnt++; if (ed !== 1) $display("FAIL big_latency got %0d want 1", ed); else pass_cnt++;
      total_cnt++; if (r !== 32'h7FFFFFFF) $display("FAIL big_int got %h want 7FFFFFFF", r); else pass_cnt++;
      total_cnt++; if (fl !== 2'b01) $display("FAIL big_flag got %b want 01", fl); else pass_cnt++;
      convert(32'hCF000000, r, fl, ed, bc, ok);
      total_cnt++; if (r !== 32'h80000000) $display("FAIL minint_int got %h want 80000000", r); else pass_cnt++;
      total_cnt++; if (fl !== 2'b00) $display("FAIL minint_flag got %b want 00", fl); else pass_cnt++;
      convert(32'hFF800000, r, fl, ed, bc, ok);
      total_cnt++; if (r !== 32'h80000000) $display("FAIL ninf_int got %h want 80000000", r); else pass_cnt++;
      total_cnt++; if (fl !== 2'b01) $display("FAIL ninf_flag got %b want 01", fl); else pass_cnt++;
      convert(32'h7F800000, r, fl, ed, bc, ok);
      total_cnt++; if (r !== 32'h7FFFFFFF) $display("FAIL pinf_int got %h want 7FFFFFFF", r); else pass_cnt++;
      total_cnt++; if (fl !== 2'b01) $display("FAIL pinf_flag got %b want 01", fl); else pass_cnt++;
   endtask

   task automatic test_special();
      logic [31:0] r; logic [1:0] fl; int ed, bc; logic ok;
      convert(32'h7FC00000, r, fl, ed, bc, ok);
      total_cnt++; if (r !== 32'h0) $display("FAIL nan_int got %h want 0", r); else pass_cnt++;
      total_cnt++; if (fl !== 2'b10) $display("FAIL nan_flag got %b want 10", fl); else pass_cnt++;
      convert(32'h80000000, r, fl, ed, bc, ok);
      total_cnt++; if (ed !== 1) $display("FAIL nzero_latency got %0d want 1", ed); else pass_cnt++;
      total_cnt++; if (r !== 32'h0) $display("FAIL nzero_int got %h want 0", r); else pass_cnt++;
      total_cnt++; if (fl !== 2'b00) $display("FAIL nzero_flag got %b want 00", fl); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      int ed;
      @(negedge clk);
      bus.float_in = 32'h43434000;
      bus.start    = 1'b1;
      @(posedge clk);
      #1;
      total_cnt++; if (bus.busy !== 1'b1) $display("FAIL b2b_accept got %b want 1", bus.busy); else pass_cnt++;
      ed = -1;
      for (int i = 1; i <= 100; i++) begin
         @(posedge clk);
         #1;
         if (bus.done) begin
            ed = i;
            break;
         end
         bus.float_in = $urandom;
      end
      total_cnt++; if (ed !== 17) $display("FAIL b2b_latency got %0d want 17", ed); else pass_cnt++;
      total_cnt++; if (bus.int_out !== 32'h000000C3) $display("FAIL b2b_int got %h want 000000C3", bus.int_out); else pass_cnt++;
      bus.float_in = 32'h42600000;
      @(posedge clk);
      #1;
      total_cnt++; if ((bus.busy | bus.done) !== 1'b0) $display("FAIL b2b_idle got busy=%b done=%b want 0 0", bus.busy, bus.done); else pass_cnt++;
      @(posedge clk);
      #1;
      total_cnt++; if (bus.busy !== 1'b1) $display("FAIL b2b_reaccept got %b want 1", bus.busy); else pass_cnt++;
      bus.start = 1'b0;
      ed = -1;
      for (int i = 1; i <= 100; i++) begin
         @(posedge clk);
         #1;
         if (bus.done) begin
            ed = i;
            break;
         end
      end
      total_cnt++; if (ed !== 19) $display("FAIL b2b2_latency got %0d want 19", ed); else pass_cnt++;
      total_cnt++; if (bus.int_out !== 32'h00000038) $display("FAIL b2b2_int got %h want 00000038", bus.int_out); else pass_cnt++;
      @(posedge clk);
      #1;
   endtask

   task automatic test_abort();
      logic [31:0] r; logic [1:0] fl; int ed, bc, dones; logic ok;
      @(negedge clk);
      bus.float_in = 32'h42600000;
      bus.start    = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      total_cnt++; if (bus.busy !== 1'b0) $display("FAIL abort_busy got %b want 0", bus.busy); else pass_cnt++;
      total_cnt++; if (bus.int_out !== 32'h0) $display("FAIL abort_int got %h want 0", bus.int_out); else pass_cnt++;
      total_cnt++; if (bus.flag_out !== 2'b00) $display("FAIL abort_flag got %b want 00", bus.flag_out); else pass_cnt++;
      @(negedge clk);
      rst_n = 1'b1;
      dones = 0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk);
         #1;
         if (bus.done) dones++;
      end
      total_cnt++; if (dones !== 0) $display("FAIL abort_nodone got %0d want 0", dones); else pass_cnt++;
      convert(32'h4B7FFFFF, r, fl, ed, bc, ok);
      total_cnt++; if (ed !== 1) $display("FAIL post_latency got %0d want 1", ed); else pass_cnt++;
      total_cnt++; if (r !== 32'h00FFFFFF) $display("FAIL post_int got %h want 00FFFFFF", r); else pass_cnt++;
      total_cnt++; if (fl !== 2'b00) $display("FAIL post_flag got %b want 00", fl); else pass_cnt++;
   endtask

   initial begin
      pass_cnt  = 0;
      total_cnt = 0;
      test_reset();
      test_right_shift();
      test_left_shift();
      test_saturation();
      test_special();
      test_back_to_back();
      test_abort();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
